// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 S-box tables, state geometry, SubBytes FSM encoding.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte idx of a state, byte 0 being the most significant.
    function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] state, input logic [3:0] idx);
        logic [STATE_W-1:0] shifted;
        shifted = state << {idx, 3'b000};
        return shifted[STATE_W-1 -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane; the inverse table exists only when INV_EN is set.
module aes_sbox_lane
    import aes_pkg::*;
#(
    parameter int unsigned INV_EN = 1
) (
    input  logic [7:0] value,
    input  logic       inv,
    output logic [7:0] sub
);

    if (INV_EN != 0) begin : g_inv
        assign sub = inv ? INV_SBOX[value] : SBOX[value];
    end else begin : g_fwd
        logic unused_inv;
        assign unused_inv = inv;
        assign sub        = SBOX[value];
    end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes: LANES bytes per cycle over BYTES/LANES cycles, valid/ready on both sides.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned STEPS = BYTES / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((LANES != 1) && (LANES != 2) && (LANES != 4) && (LANES != 8) && (LANES != 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [STATE_W-1:0] st_q, st_step;
    logic               mode_q;
    logic               load, step, last;
    logic [7:0]         lane_in  [LANES];
    logic [7:0]         lane_out [LANES];

    assign last      = (cnt_q == CNT_W'(STEPS - 1));
    assign out_state = st_q;

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        assign lane_in[l] = get_byte(st_q, 4'(int'(cnt_q) * int'(LANES) + l));

        aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .value (lane_in[l]),
            .inv   (mode_q),
            .sub   (lane_out[l])
        );
    end

    // Write the current group of substituted bytes back in place.
    always_comb begin : p_merge
        st_step = st_q;
        for (int l = 0; l < int'(LANES); l++) begin
            st_step[int'(STATE_W) - 1 - 8 * (int'(cnt_q) * int'(LANES) + l) -: 8] = lane_out[l];
        end
    end

    always_comb begin : p_fsm
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_data
        if (!rst_n) begin
            st_q   <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            st_q   <= in_state;
            cnt_q  <= '0;
            mode_q <= (INV_EN != 0) ? in_inv : 1'b0;
        end else if (step) begin
            st_q   <= st_step;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine across several LANES/INV_EN configurations.
module tb_sub_bytes_engine;

    localparam int unsigned NDUT = 5;
    localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL_63  = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALL_FB  = 128'hfbfbfbfbfbfbfbfbfbfbfbfbfbfbfbfb;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [NDUT-1:0]            iv, ordy, ir, ov, bz;
    logic [127:0]               in_state;
    logic                       in_inv;
    logic [NDUT-1:0][127:0]     os;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: LANES=4 with inverse, 1: LANES=1, 2: LANES=16, 3: LANES=2, 4: LANES=4 forward only
    sub_bytes_engine #(.LANES(4), .INV_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state), .in_inv(in_inv),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0]), .busy(bz[0]));
    sub_bytes_engine #(.LANES(1), .INV_EN(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state), .in_inv(in_inv),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1]), .busy(bz[1]));
    sub_bytes_engine #(.LANES(16), .INV_EN(1)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state), .in_inv(in_inv),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2]), .busy(bz[2]));
    sub_bytes_engine #(.LANES(2), .INV_EN(1)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_state(in_state), .in_inv(in_inv),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_state(os[3]), .busy(bz[3]));
    sub_bytes_engine #(.LANES(4), .INV_EN(0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_state(in_state), .in_inv(in_inv),
        .out_valid(ov[4]), .out_ready(ordy[4]), .out_state(os[4]), .busy(bz[4]));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on DUT k; in_inv is flipped right after accept to show it is latched.
    task automatic run_txn(input int k, input string tag, input logic [127:0] st, input logic inv,
                           input logic [127:0] exp, input int lat, input logic hold_ready);
        int n;
        check_eq({tag, "_in_ready"}, 128'(ir[k]), 128'(1));
        iv[k]    = 1'b1;
        in_state = st;
        in_inv   = inv;
        ordy[k]  = hold_ready;
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        in_inv = ~inv;
        n = 0;
        while (!ov[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, 128'(n), 128'(lat));
        check_eq({tag, "_out_state"}, os[k], exp);
        if (!hold_ready) ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        check_eq({tag, "_valid_drop"}, 128'(ov[k]), 128'(0));
        check_eq({tag, "_ready_back"}, 128'(ir[k]), 128'(1));
        check_eq({tag, "_busy_clear"}, 128'(bz[k]), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        iv       = '0;
        ordy     = '0;
        in_state = '0;
        in_inv   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < int'(NDUT); k++) begin
            check_eq($sformatf("rst_out_valid_%0d", k), 128'(ov[k]), 128'(0));
            check_eq($sformatf("rst_busy_%0d", k), 128'(bz[k]), 128'(0));
            check_eq($sformatf("rst_out_state_%0d", k), os[k], 128'(0));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < int'(NDUT); k++) begin
            check_eq($sformatf("post_rst_in_ready_%0d", k), 128'(ir[k]), 128'(1));
        end

        run_txn(0, "l4_fwd",  VEC_IN,  1'b0, VEC_OUT, 4,  1'b0);
        run_txn(1, "l1_fwd",  VEC_IN,  1'b0, VEC_OUT, 16, 1'b0);
        run_txn(2, "l16_fwd", VEC_IN,  1'b0, VEC_OUT, 1,  1'b0);
        run_txn(3, "l2_fwd",  VEC_IN,  1'b0, VEC_OUT, 8,  1'b0);
        run_txn(0, "l4_inv",  VEC_OUT, 1'b1, VEC_IN,  4,  1'b0);
        run_txn(1, "l1_inv",  VEC_OUT, 1'b1, VEC_IN,  16, 1'b0);
        run_txn(0, "l4_zero", 128'(0), 1'b0, ALL_63,  4,  1'b0);
        run_txn(4, "noinv",   ALL_63,  1'b1, ALL_FB,  4,  1'b0);
        run_txn(0, "rdy_hi",  VEC_IN,  1'b0, VEC_OUT, 4,  1'b1);
        run_txn(2, "l16_rdy", ALL_63,  1'b1, 128'(0), 1,  1'b1);

        // Backpressure: hold the result while the producer keeps offering new states.
        iv[0]    = 1'b1;
        in_state = VEC_IN;
        in_inv   = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("bp_latency", 128'(n), 128'(4));
        for (int c = 0; c < 10; c++) begin
            iv[0]    = 1'b1;
            in_state = 128'(c);
            in_inv   = c[0];
            @(posedge clk); #1;
            check_eq($sformatf("bp_state_%0d", c), os[0], VEC_OUT);
            check_eq($sformatf("bp_valid_%0d", c), 128'(ov[0]), 128'(1));
            check_eq($sformatf("bp_in_ready_%0d", c), 128'(ir[0]), 128'(0));
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check_eq("bp_release_valid", 128'(ov[0]), 128'(0));
        check_eq("bp_release_ready", 128'(ir[0]), 128'(1));
        @(posedge clk); #1;
        check_eq("bp_no_ghost_busy", 128'(bz[0]), 128'(0));

        // Reset in the middle of BUSY with cnt at 2.
        iv[0]    = 1'b1;
        in_state = VEC_IN;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_busy_before_rst", 128'(bz[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 128'(ov[0]), 128'(0));
        check_eq("mid_rst_busy", 128'(bz[0]), 128'(0));
        check_eq("mid_rst_state", os[0], 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(0, "after_rst", VEC_IN, 1'b0, VEC_OUT, 4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
